mem_store_unit: RTL and testbench
=================================

MEM_STORE_UNIT -- requirements
Module: mem_store_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the store data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, the byte address width.
REQ-003 SHALL have parameter MEM_SIZE, default 512, the memory depth in 32-bit words.
REQ-004 SHALL have port clk  input  1  -- the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  input  1  -- reset, asynchronous assert, active-low.
REQ-006 SHALL have port req_valid  input  1  -- a store request is present.
REQ-007 SHALL have port req_ready  output  1  -- the unit can accept a request this cycle.
REQ-008 SHALL have port req_addr  input  ADDR_WIDTH  -- byte address, any alignment.
REQ-009 SHALL have port req_data  input  DATA_WIDTH  -- store data, right-justified.
REQ-010 SHALL have port req_store_type  input  3  -- 000 SB, 001 SH, 010 SW; all other codes invalid.
REQ-011 SHALL have port mem_we  output  1  -- word write strobe.
REQ-012 SHALL have port mem_addr  output  ADDR_WIDTH-2  -- word index.
REQ-013 SHALL have port mem_wdata  output  DATA_WIDTH  -- lane-aligned write data.
REQ-014 SHALL have port mem_wstrb  output  4  -- byte enables; bit i enables byte lane i.
REQ-015 SHALL have port done  output  1  -- one-cycle pulse when a request retires.
REQ-016 SHALL have port err  output  1  -- one-cycle pulse on a faulted request.
REQ-017 SHALL have port busy  output  1  -- high whenever state is not IDLE.

Function
REQ-018 SHALL accept a request on the cycle where req_valid and req_ready are both high (the handshake).
REQ-019 SHALL register all mem_* outputs, plus done and err; a request accepted in cycle N drives its first beat in cycle N+1.
REQ-020 SHALL use the FSM states IDLE, BEAT0 and BEAT1, with these transitions:
- IDLE to BEAT0 on handshake.
- BEAT0 to BEAT1 if the request crosses a word boundary.
- BEAT0 to BEAT0 if it does not cross and a new handshake occurs.
- BEAT0 to IDLE otherwise.
- BEAT1 to BEAT0 on handshake, else to IDLE.
REQ-021 SHALL drive req_ready high in IDLE, in BEAT1, and in BEAT0 only when the current request is single-beat; this sustains one aligned store per cycle.
REQ-022 SHALL form the lane data and strobes as follows:
- Data: zero-extend req_data to 64 bits and shift left by 8*addr[1:0].
- Strobes: take the type mask (SB 0001, SH 0011, SW 1111), zero-extend it to 8 bits and shift left by addr[1:0].
- Beat0 uses bits [31:0] and [3:0] of these; beat1 uses bits [63:32] and [7:4].
REQ-023 SHALL treat a request as crossing when the strobe bits [7:4] are nonzero; beat0 targets word addr[ADDR_WIDTH-1:2] and beat1 targets that word index plus one.
REQ-024 SHALL suppress mem_we for any beat whose word index is at or above MEM_SIZE; the beat still occupies its cycle, and err pulses with done.
REQ-025 SHALL handle an invalid store type by accepting it, asserting no mem_we, and pulsing done and err in cycle N+1.
REQ-026 SHALL pulse done in the same cycle as the last beat of the request.
REQ-027 SHALL hold mem_we, mem_wstrb, done and err at zero in every cycle with no beat.

Reset
REQ-028 SHALL, while rst_n is low, force the state to IDLE and drive mem_we, mem_addr, mem_wdata, mem_wstrb, done, err and busy to zero and req_ready to zero.
REQ-029 SHALL discard any pending beat1 when rst_n asserts mid-request, with no partial write emitted after reset; req_ready rises in the first cycle after rst_n deasserts.

Configuration
REQ-030 SHALL, when MISALIGNED_SPLIT_EN is defined, split crossing requests into two beats as specified above.
REQ-031 SHALL, when MISALIGNED_SPLIT_EN is undefined, accept a crossing request, assert no mem_we for it, and pulse done and err in cycle N+1; BEAT1 is then unreachable.

Structure
REQ-032 SHALL take the store-type codes (SB, SH, SW), the byte-mask constants and the NOP-free memory word type from the shared package mem_pkg.
REQ-033 SHALL place the combinational shift and strobe generation of REQ-022 in a sub-module store_lane_align.

Verification
REQ-034 SHALL verify: SB, addr 0x103, data 0xAB -> at N+1 mem_addr 0x40, wstrb 1000, wdata 0xAB000000, done high.
REQ-035 SHALL verify: SW, addr 0x101, data 0x11223344 -> beat0 0x40/1110/0x22334400; beat1 0x41/0001/0x00000011; done with beat1.
REQ-036 SHALL verify: SH, addr 0x007, data 0xBEEF -> beat0 0x01/1000/0xEF000000; beat1 0x02/0001/0x000000BE; with the macro undefined -> no mem_we, err and done at N+1.
REQ-037 SHALL verify: SW to 0x7FE with MEM_SIZE 512 -> beat0 writes word 511 with strobe 1100; beat1 has mem_we low, err and done high.
REQ-038 SHALL verify: three back-to-back aligned SW at 0x0, 0x4, 0x8 -> mem_we high three consecutive cycles and req_ready never low.
REQ-039 SHALL verify: req_store_type 011 -> no mem_we, err and done at N+1; rst_n low during BEAT0 of a crossing SW -> no beat1 emitted and all outputs zero.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the store path: store-type codes, byte masks, word type and FSM states.
package mem_pkg;

  localparam logic [2:0] ST_SB = 3'b000;
  localparam logic [2:0] ST_SH = 3'b001;
  localparam logic [2:0] ST_SW = 3'b010;

  localparam logic [3:0] MASK_SB = 4'b0001;
  localparam logic [3:0] MASK_SH = 4'b0011;
  localparam logic [3:0] MASK_SW = 4'b1111;

  typedef logic [31:0] mem_word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    BEAT0 = 2'b01,
    BEAT1 = 2'b10
  } msu_state_t;

  // An all-zero mask marks an invalid store type.
  function automatic logic [3:0] type_mask(input logic [2:0] st);
    case (st)
      ST_SB:   type_mask = MASK_SB;
      ST_SH:   type_mask = MASK_SH;
      ST_SW:   type_mask = MASK_SW;
      default: type_mask = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/store_lane_align.sv
// Shifts store data and byte strobes into a two-word (64-bit / 8-lane) window by the byte offset.
module store_lane_align
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [1:0]            i_addr_lo,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [2:0]            i_store_type,
  output logic [63:0]           o_lane_data,
  output logic [7:0]            o_lane_strb,
  output logic                  o_type_ok
);

  logic [3:0]  w_mask;
  logic [63:0] w_ext;

  // Lane alignment of data and strobes.
  always_comb begin
    w_mask      = type_mask(i_store_type);
    w_ext       = 64'(i_data);
    o_lane_data = w_ext << {i_addr_lo, 3'b000};
    o_lane_strb = {4'b0000, w_mask} << i_addr_lo;
    o_type_ok   = (w_mask != 4'b0000);
  end

endmodule

// File: rtl/mem_store_unit.sv
// Byte/half/word store unit with registered memory write port; crossing stores are split into
// two beats only when MISALIGNED_SPLIT_EN is defined, otherwise they are faulted.
module mem_store_unit
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_SIZE   = 512
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_data,
  input  logic [2:0]            req_store_type,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-3:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_wstrb,
  output logic                  done,
  output logic                  err,
  output logic                  busy
);

  localparam int WW = ADDR_WIDTH - 2;
  localparam logic [ADDR_WIDTH-1:0] MEM_WORDS = ADDR_WIDTH'(MEM_SIZE);

  msu_state_t r_state, w_state_nxt;
  logic        r_rdy_en, r_cross, r_inb1, r_err_pend;
  logic [WW-1:0] r_word1;
  mem_word_t   r_hi_data;
  logic [3:0]  r_hi_strb;

  logic                  r_mem_we, r_done, r_err;
  logic [WW-1:0]         r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  logic [3:0]            r_mem_wstrb;

  logic          w_ready, w_hs, w_ld_beat1;
  logic [63:0]   w_lane_data;
  logic [7:0]    w_lane_strb;
  logic          w_type_ok, w_cross, w_split, w_inb0, w_inb1, w_fault0;
  logic [WW-1:0] w_word0, w_word1;

  store_lane_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .i_addr_lo    (req_addr[1:0]),
    .i_data       (req_data),
    .i_store_type (req_store_type),
    .o_lane_data  (w_lane_data),
    .o_lane_strb  (w_lane_strb),
    .o_type_ok    (w_type_ok)
  );

  // Request classification: target words, bounds and crossing.
  always_comb begin
    w_word0  = req_addr[ADDR_WIDTH-1:2];
    w_word1  = w_word0 + WW'(1);
    w_inb0   = ({2'b00, w_word0} < MEM_WORDS);
    w_inb1   = (({2'b00, w_word0} + ADDR_WIDTH'(1)) < MEM_WORDS);
    w_cross  = |w_lane_strb[7:4];
`ifdef MISALIGNED_SPLIT_EN
    w_split  = w_cross & w_type_ok;
`else
    w_split  = 1'b0;
`endif
    w_fault0 = ~w_type_ok | (w_cross & ~w_split) | ~w_inb0;
  end

  // Ready decode; r_rdy_en keeps ready low through reset and its first edge.
  always_comb begin
    w_ready = 1'b0;
    case (r_state)
      IDLE:    w_ready = r_rdy_en;
      BEAT0:   w_ready = r_rdy_en & ~r_cross;
      BEAT1:   w_ready = r_rdy_en;
      default: w_ready = 1'b0;
    endcase
  end

  assign w_hs = req_valid & w_ready;

  // Next-state logic.
  always_comb begin
    w_state_nxt = IDLE;
    w_ld_beat1  = 1'b0;
    case (r_state)
      IDLE:  w_state_nxt = w_hs ? BEAT0 : IDLE;
      BEAT0: begin
        if (r_cross) begin
          w_state_nxt = BEAT1;
          w_ld_beat1  = 1'b1;
        end else begin
          w_state_nxt = w_hs ? BEAT0 : IDLE;
        end
      end
      BEAT1:   w_state_nxt = w_hs ? BEAT0 : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register and captured second-beat context.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_rdy_en   <= 1'b0;
      r_cross    <= 1'b0;
      r_inb1     <= 1'b0;
      r_err_pend <= 1'b0;
      r_word1    <= '0;
      r_hi_data  <= '0;
      r_hi_strb  <= 4'b0000;
    end else begin
      r_state  <= w_state_nxt;
      r_rdy_en <= 1'b1;
      if (w_hs) begin
        r_cross    <= w_split;
        r_inb1     <= w_inb1;
        r_err_pend <= ~w_inb0;
        r_word1    <= w_word1;
        r_hi_data  <= w_lane_data[63:32];
        r_hi_strb  <= w_lane_strb[7:4];
      end else if (w_ld_beat1) begin
        r_cross <= 1'b0;
      end
    end
  end

  // Registered memory port and status pulses; strobes/pulses default to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_wstrb <= 4'b0000;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_mem_we    <= 1'b0;
      r_mem_wstrb <= 4'b0000;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      if (w_hs) begin
        r_mem_we    <= ~w_fault0;
        r_mem_addr  <= w_word0;
        r_mem_wdata <= DATA_WIDTH'(w_lane_data[31:0]);
        r_mem_wstrb <= w_fault0 ? 4'b0000 : w_lane_strb[3:0];
        r_done      <= ~w_split;
        r_err       <= ~w_split & w_fault0;
      end else if (w_ld_beat1) begin
        r_mem_we    <= r_inb1;
        r_mem_addr  <= r_word1;
        r_mem_wdata <= DATA_WIDTH'(r_hi_data);
        r_mem_wstrb <= r_inb1 ? r_hi_strb : 4'b0000;
        r_done      <= 1'b1;
        r_err       <= r_err_pend | ~r_inb1;
      end
    end
  end

  assign req_ready = w_ready;
  assign busy      = (r_state != IDLE);
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_wstrb = r_mem_wstrb;
  assign done      = r_done;
  assign err       = r_err;

endmodule

// File: tb/tb_mem_store_unit.sv
// Directed self-checking bench for mem_store_unit; expectations follow MISALIGNED_SPLIT_EN.
module tb_mem_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_data = 32'h0;
  logic [2:0]  req_store_type = 3'b000;
  logic        mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        done, err, busy;

  int n_checks = 0;
  int n_fail   = 0;

  mem_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_SIZE(512)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .req_store_type(req_store_type),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .done(done), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_beat(input string tag, input logic we, input logic [29:0] addr,
                            input logic [3:0] strb, input logic [31:0] wd,
                            input logic dn, input logic er);
    check_eq({tag, ".we"}, 64'(mem_we), 64'(we));
    if (we) begin
      check_eq({tag, ".addr"}, 64'(mem_addr), 64'(addr));
      check_eq({tag, ".strb"}, 64'(mem_wstrb), 64'(strb));
      check_eq({tag, ".wdata"}, 64'(mem_wdata), 64'(wd));
    end
    check_eq({tag, ".done"}, 64'(done), 64'(dn));
    check_eq({tag, ".err"}, 64'(err), 64'(er));
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, ".we"}, 64'(mem_we), 64'd0);
    check_eq({tag, ".strb"}, 64'(mem_wstrb), 64'd0);
    check_eq({tag, ".done"}, 64'(done), 64'd0);
    check_eq({tag, ".err"}, 64'(err), 64'd0);
    check_eq({tag, ".busy"}, 64'(busy), 64'd0);
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [2:0] t);
    check_eq("send.ready", 64'(req_ready), 64'd1);
    req_valid      = 1'b1;
    req_addr       = a;
    req_data       = d;
    req_store_type = t;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst.ready", 64'(req_ready), 64'd0);
    check_eq("rst.addr", 64'(mem_addr), 64'd0);
    check_eq("rst.wdata", 64'(mem_wdata), 64'd0);
    check_idle("rst");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("post_rst.ready", 64'(req_ready), 64'd1);

    // SB at 0x103
    send(32'h103, 32'hAB, 3'b000);
    check_beat("sb", 1'b1, 30'h40, 4'b1000, 32'hAB00_0000, 1'b1, 1'b0);
    check_eq("sb.busy", 64'(busy), 64'd1);
    @(posedge clk); #1;
    check_idle("sb.after");

    // SW at 0x101 (crossing)
    send(32'h101, 32'h1122_3344, 3'b010);
`ifdef MISALIGNED_SPLIT_EN
    check_beat("sw_x.b0", 1'b1, 30'h40, 4'b1110, 32'h2233_4400, 1'b0, 1'b0);
    check_eq("sw_x.b0.ready", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    check_beat("sw_x.b1", 1'b1, 30'h41, 4'b0001, 32'h0000_0011, 1'b1, 1'b0);
`else
    check_beat("sw_x", 1'b0, 30'h0, 4'b0000, 32'h0, 1'b1, 1'b1);
`endif
    @(posedge clk); #1;
    check_idle("sw_x.after");

    // SH at 0x007 (crossing)
    send(32'h7, 32'hBEEF, 3'b001);
`ifdef MISALIGNED_SPLIT_EN
    check_beat("sh_x.b0", 1'b1, 30'h01, 4'b1000, 32'hEF00_0000, 1'b0, 1'b0);
    @(posedge clk); #1;
    check_beat("sh_x.b1", 1'b1, 30'h02, 4'b0001, 32'h0000_00BE, 1'b1, 1'b0);
`else
    check_beat("sh_x", 1'b0, 30'h0, 4'b0000, 32'h0, 1'b1, 1'b1);
`endif
    @(posedge clk); #1;
    check_idle("sh_x.after");

    // SW at 0x7FE: second word is past the end of memory
    send(32'h7FE, 32'hCAFE_F00D, 3'b010);
`ifdef MISALIGNED_SPLIT_EN
    check_beat("sw_end.b0", 1'b1, 30'h1FF, 4'b1100, 32'hF00D_0000, 1'b0, 1'b0);
    @(posedge clk); #1;
    check_beat("sw_end.b1", 1'b0, 30'h0, 4'b0000, 32'h0, 1'b1, 1'b1);
`else
    check_beat("sw_end", 1'b0, 30'h0, 4'b0000, 32'h0, 1'b1, 1'b1);
`endif
    @(posedge clk); #1;
    check_idle("sw_end.after");

    // Last valid word, then first invalid word
    send(32'h7FC, 32'h1234_5678, 3'b010);
    check_beat("sw_last", 1'b1, 30'h1FF, 4'b1111, 32'h1234_5678, 1'b1, 1'b0);
    @(posedge clk); #1;
    send(32'h800, 32'h1234_5678, 3'b010);
    check_beat("sw_oob", 1'b0, 30'h0, 4'b0000, 32'h0, 1'b1, 1'b1);
    @(posedge clk); #1;

    // Invalid store type
    send(32'h10, 32'h5555_AAAA, 3'b011);
    check_beat("bad_type", 1'b0, 30'h0, 4'b0000, 32'h0, 1'b1, 1'b1);
    @(posedge clk); #1;
    check_idle("bad_type.after");

    // Three back-to-back aligned SW
    req_valid = 1'b1; req_store_type = 3'b010;
    req_addr = 32'h0; req_data = 32'hA0A0_A0A0;
    check_eq("b2b.rdy0", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    check_beat("b2b0", 1'b1, 30'h0, 4'b1111, 32'hA0A0_A0A0, 1'b1, 1'b0);
    req_addr = 32'h4; req_data = 32'hA1A1_A1A1;
    check_eq("b2b.rdy1", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    check_beat("b2b1", 1'b1, 30'h1, 4'b1111, 32'hA1A1_A1A1, 1'b1, 1'b0);
    req_addr = 32'h8; req_data = 32'hA2A2_A2A2;
    check_eq("b2b.rdy2", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    check_beat("b2b2", 1'b1, 30'h2, 4'b1111, 32'hA2A2_A2A2, 1'b1, 1'b0);
    req_valid = 1'b0;
    check_eq("b2b.rdy3", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    check_idle("b2b.after");

    // Reset asserted during the first beat of a crossing SW
    send(32'h101, 32'h1122_3344, 3'b010);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("midrst.ready", 64'(req_ready), 64'd0);
    check_eq("midrst.addr", 64'(mem_addr), 64'd0);
    check_eq("midrst.wdata", 64'(mem_wdata), 64'd0);
    check_idle("midrst");
    @(posedge clk); #1;
    check_idle("midrst.hold");
    rst_n = 1'b1;
    check_eq("midrst.rel.ready", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    check_eq("midrst.post.ready", 64'(req_ready), 64'd1);
    check_idle("midrst.post");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
